im_port_arbiter: RTL and testbench
==================================

Name: im_port_arbiter

Overview:
- Arbitrates the single port of the 32x32 instruction memory between two requesters: the CPU fetch path (read-only) and the program loader (write-only bursts).
- The loader preloads or patches programs at runtime. Fetch must not starve during a long load.
- Sits between the PC/fetch logic and a synchronous-read instruction memory macro.

Parameters:
- ADDR_W, 5, memory word-index width (2^ADDR_W words).
- DATA_W, 32, instruction width.
- MAX_BURST, 8, consecutive loader beats after which a pending fetch is forced a grant (range 1..2^ADDR_W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  fetch read request.
- fetch_addr  input  10  word index from the PC.
- fetch_gnt  output  1  fetch accepted this cycle.
- fetch_rvalid  output  1  fetch_rdata is valid this cycle.
- fetch_rdata  output  DATA_W  fetched instruction.
- fetch_oob  output  1  pulses with fetch_rvalid when the returned fetch address had bits [9:ADDR_W] nonzero.
- ld_valid  input  1  loader beat valid.
- ld_ready  output  1  loader beat may be accepted.
- ld_addr  input  ADDR_W  write word index.
- ld_wdata  input  DATA_W  write data.
- ld_last  input  1  final beat of the burst.
- busy_loading  output  1  burst in progress (state LOAD).
- mem_en  output  1  memory port enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after a read enable.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, beat counter cnt=0, pending-read flags cleared.
  - All outputs 0 while rst_n is low, including combinational outputs (ld_ready, fetch_gnt, mem_*).
- States: IDLE, LOAD.
- Loader handshake:
  - Beat accepted = ld_valid && ld_ready.
  - ld_ready does not depend on ld_valid.
  - ld_ready = !yield, where yield = (state==LOAD && cnt==MAX_BURST && fetch_req).
- Fetch grant:
  - fetch_gnt = fetch_req && !(ld_valid && ld_ready).
  - The loader wins any simultaneous request unless yield is active.
  - In LOAD with ld_valid low, a fetch is granted with no penalty cycle.
- Memory drive (combinational from the grant):
  - Loader beat: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata.
  - Fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W-1:0], mem_wdata=0.
  - Neither: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read latency is 1 cycle:
  - Registered flag: fetch_rvalid is high the cycle after fetch_gnt.
  - fetch_rdata=mem_rdata, or 0 (NOP) if the registered out-of-range flag is set. In that case fetch_oob=1 in the same cycle.
  - fetch_rdata=0 whenever fetch_rvalid=0.
- Transitions:
  - IDLE -> LOAD on an accepted beat with ld_last=0; cnt=1.
  - IDLE stays IDLE on an accepted beat with ld_last=1 (single-beat patch); cnt stays 0.
  - LOAD, accepted beat with ld_last=1: -> IDLE, cnt=0.
  - LOAD, accepted beat with ld_last=0: cnt=min(cnt+1, MAX_BURST).
  - LOAD, yield cycle: fetch granted, no loader beat, cnt reset to 0, stay LOAD.
  - LOAD, cnt==MAX_BURST and fetch_req=0: the loader continues; cnt saturates.
- Read-after-write:
  - A write at cycle N followed by a fetch of the same address at cycle N+1 returns the new data at N+2.
  - Same-cycle read/write is impossible by construction.
- ld_last on a non-accepted cycle is ignored.
- Reset asserted mid-burst aborts the burst. The memory contents written so far are retained (not owned by this block). The first loader beat after reset starts a new burst from IDLE.
- Out-of-range fetch still performs a memory read (address truncated); only the returned data is forced to 0.

Test Plan:
- Reset then fetch_req=1, fetch_addr=3 with mem[3]=0x20080005 -> fetch_gnt=1 at cycle 0; fetch_rvalid=1, fetch_rdata=0x20080005 at cycle 1; all outputs 0 during reset.
- Loader writes 4 beats, addr 0..3, data 0xA0..0xA3, ld_last on beat 3, no fetch -> ld_ready=1 throughout; busy_loading=1 from beat 1 through beat 3; back to IDLE after beat 3; mem writes match.
- MAX_BURST=8, 12-beat burst with fetch_req held high from beat 0 -> beats 0-7 are granted to the loader; the cycle after beat 7 has ld_ready=0 and fetch_gnt=1; beats 8-11 follow; burst completion takes 13 cycles.
- Write 0xDEADBEEF to addr 5, then fetch addr 5 the next cycle -> fetch_rdata=0xDEADBEEF one cycle later.
- fetch_addr=10'h020 with mem[0]=0x1234 -> fetch_rvalid=1, fetch_rdata=0, fetch_oob=1.
- Assert rst_n low asynchronously mid-burst (after beat 2 of 6) -> busy_loading and ld_ready drop immediately; after release, a new ld_last=1 single beat leaves state IDLE and busy_loading=0.

Source files
------------

// File: rtl/im_port_arbiter.sv
// Single-port instruction memory arbiter: CPU fetch (read) vs program loader (write bursts).
// The loader normally wins, but after MAX_BURST consecutive beats a waiting fetch gets one slot.
module im_port_arbiter #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_req_i,
   input  logic [9:0]        fetch_addr_i,
   output logic              fetch_gnt_o,
   output logic              fetch_rvalid_o,
   output logic [DATA_W-1:0] fetch_rdata_o,
   output logic              fetch_oob_o,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_wdata_i,
   input  logic              ld_last_i,
   output logic              busy_loading_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

   typedef enum logic [0:0] {StIdle, StLoad} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rvalid_q, oob_q;
   logic            yield, beat, fetch_gnt, addr_oob;

   // Fetch has waited out a full burst: steal exactly one slot from the loader.
   assign yield     = (state_q == StLoad) && (cnt_q == MaxCnt) && fetch_req_i;
   assign beat      = rst_ni && ld_valid_i && !yield;
   assign fetch_gnt = rst_ni && fetch_req_i && !beat;
   assign addr_oob  = (fetch_addr_i >> ADDR_W) != 10'd0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         oob_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= fetch_gnt;
         oob_q    <= fetch_gnt && addr_oob;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (beat && !ld_last_i) begin
               state_d = StLoad;
               cnt_d   = CntW'(1);
            end
         end
         StLoad: begin
            if (beat) begin
               if (ld_last_i) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q != MaxCnt) begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end else if (yield) begin
               cnt_d = '0;
            end
         end
      endcase
   end

   always_comb begin
      ld_ready_o     = rst_ni && !yield;
      fetch_gnt_o    = fetch_gnt;
      busy_loading_o = (state_q == StLoad);
      fetch_rvalid_o = rvalid_q;
      fetch_oob_o    = oob_q;
      // Out-of-range fetches still read memory; only the returned word becomes a NOP.
      fetch_rdata_o  = (rvalid_q && !oob_q) ? mem_rdata_i : '0;
      mem_en_o       = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      if (beat) begin
         mem_en_o    = 1'b1;
         mem_we_o    = 1'b1;
         mem_addr_o  = ld_addr_i;
         mem_wdata_o = ld_wdata_i;
      end else if (fetch_gnt) begin
         mem_en_o    = 1'b1;
         mem_addr_o  = fetch_addr_i[ADDR_W-1:0];
      end
   end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Randomised scoreboard bench for im_port_arbiter with a sync-read memory model attached.
module tb_im_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_req, fetch_gnt, fetch_rvalid, fetch_oob;
   logic [9:0]    fetch_addr;
   logic [DW-1:0] fetch_rdata;
   logic          ld_valid, ld_ready, ld_last, busy_loading;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   im_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
      .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_oob_o(fetch_oob),
      .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr),
      .ld_wdata_i(ld_wdata), .ld_last_i(ld_last), .busy_loading_o(busy_loading),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // Instruction memory macro: synchronous read, one-cycle latency.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int due; bit rdy; bit gnt; bit busy; logic [38:0] mbus;} comb_t;
   typedef struct {int due; logic [DW-1:0] data; bit oob;} rd_t;
   comb_t cq[$];
   rd_t   rq[$];

   // Reference model: burst flag, beats since burst start/last yield, memory image.
   bit            in_burst;
   int            run;
   logic [DW-1:0] ref_mem [32];
   bit            acc;

   int n_chk = 0;
   int n_err = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: the only place comparisons happen.
   always @(negedge clk) begin
      comb_t c;
      rd_t   r;
      if (!rst_n) begin
         chk("reset_outputs", {ld_ready, fetch_gnt, busy_loading, fetch_rvalid, fetch_oob,
                               mem_en, mem_we, mem_addr, mem_wdata, fetch_rdata}, 64'd0);
      end else begin
         if (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            chk("ld_ready", 64'(ld_ready), 64'(c.rdy));
            chk("fetch_gnt", 64'(fetch_gnt), 64'(c.gnt));
            chk("busy_loading", 64'(busy_loading), 64'(c.busy));
            chk("mem_bus", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'(c.mbus));
         end
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("fetch_rvalid", 64'(fetch_rvalid), 64'd1);
            chk("fetch_rdata", 64'(fetch_rdata), 64'(r.data));
            chk("fetch_oob", 64'(fetch_oob), 64'(r.oob));
         end else begin
            chk("idle_read_port", 64'({fetch_rvalid, fetch_oob, fetch_rdata}), 64'd0);
         end
      end
   end

   task automatic step(input bit fr, input logic [9:0] fa, input bit lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] lw, input bit ll);
      bit          yld, bt, gnt, oob;
      logic [38:0] mb;
      @(posedge clk);
      #1;
      fetch_req = fr; fetch_addr = fa; ld_valid = lv;
      ld_addr = la; ld_wdata = lw; ld_last = ll;
      #3;
      yld = in_burst && (run >= MB) && fr;
      bt  = lv && !yld;
      gnt = fr && !bt;
      oob = (fa >= 10'd32);
      if (bt)       mb = {1'b1, 1'b1, la, lw};
      else if (gnt) mb = {1'b1, 1'b0, fa[AW-1:0], 32'd0};
      else          mb = '0;
      cq.push_back('{cyc, !yld, gnt, in_burst, mb});
      if (gnt) rq.push_back('{cyc + 1, oob ? 32'd0 : ref_mem[fa[AW-1:0]], oob});
      if (bt) begin
         ref_mem[la] = lw;
         if (ll) begin in_burst = 0; run = 0; end
         else    begin in_burst = 1; run++;   end
      end else if (yld) begin
         run = 0;
      end
      acc = bt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 10'd0, 0, '0, '0, 0);
   endtask

   // Asynchronous reset mid-cycle with every request asserted, so the zero checks bite.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      in_burst = 0; run = 0;
      cq.delete(); rq.delete();
      #1;
      fetch_req = 1; fetch_addr = 10'h3ff; ld_valid = 1; ld_addr = '1;
      ld_wdata = '1; ld_last = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      fetch_req = 0; ld_valid = 0;
      @(posedge clk);
      #3;
      rst_n = 1;
   endtask

   initial begin
      int b;
      logic [DW-1:0] d;
      rst_n = 0;
      fetch_req = 1; fetch_addr = 10'd3; ld_valid = 1; ld_addr = '0;
      ld_wdata = '1; ld_last = 1;
      in_burst = 0; run = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      #22;
      fetch_req = 0; ld_valid = 0;
      #6;
      rst_n = 1;

      // Preload the whole memory with one long burst (no fetch, counter saturates).
      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         if (i == 0) d = 32'h0000_1234;
         if (i == 3) d = 32'h2008_0005;
         step(0, 10'd0, 1, AW'(i), d, i == 31);
      end
      idle(1);
      do_reset();

      // Plain fetch straight after reset.
      step(1, 10'd3, 0, '0, '0, 0);
      idle(1);
      // Out-of-range fetch: memory is read but the word comes back as NOP.
      step(1, 10'h020, 0, '0, '0, 0);
      idle(1);

      // Four-beat burst with no fetch traffic.
      for (int i = 0; i < 4; i++) step(0, 10'd0, 1, AW'(i), 32'hA0 + i, i == 3);
      idle(1);

      // Twelve-beat burst with fetch held high: one yield slot after beat 7.
      b = 0;
      for (int c = 0; c < 40 && b < 12; c++) begin
         step(1, 10'd7, 1, AW'(b + 8), 32'hB0 + b, b == 11);
         if (acc) b++;
      end
      idle(1);

      // Read-after-write on consecutive cycles.
      step(0, 10'd0, 1, AW'(5), 32'hDEAD_BEEF, 1);
      step(1, 10'd5, 0, '0, '0, 0);
      idle(1);

      // Reset in the middle of a six-beat burst, then a single-beat patch.
      for (int i = 0; i < 3; i++) step(0, 10'd0, 1, AW'(20 + i), 32'hC0 + i, 0);
      do_reset();
      step(0, 10'd0, 1, AW'(9), 32'h0000_0C99, 1);
      step(1, 10'd9, 0, '0, '0, 0);
      idle(1);

      // Random traffic, with one reset thrown in.
      for (int i = 0; i < 400; i++) begin
         logic [9:0] fa;
         fa = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
         step(($urandom_range(0, 1) == 1), fa, ($urandom_range(0, 3) != 0),
              AW'($urandom), $urandom, ($urandom_range(0, 5) == 0));
         if (i == 200) do_reset();
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
